// File: rtl/fetch_decode.sv
// Purpose : multi-cycle instruction fetch/decode controller (IDLE/FETCH/DECODE/EXECUTE/HALT).
// Latency : fetch-to-fetch 3 cycles when instr_valid returns in the first FETCH cycle.
// Backpressure: FETCH holds (instr_req=1) until instr_valid; instr_valid ignored elsewhere.
//
// Ports:
//   clock, reset        - clock and synchronous active-high reset
//   run                 - leave IDLE and start fetching
//   PC                  - program counter from the datapath; PC[9:0] is the fetch address
//   instr_data/valid    - instruction memory response, accepted only in FETCH
//   instr_req/addr      - fetch request and address
//   alucode, op1, op2, imControl, flag, flag1, writecode,
//   regenable, ramenable, pcControl
//                       - decoded controls to the datapath; operand fields are driven from IR
//                         at all times, strobes and codes only in EXECUTE
//   halted              - high while in HALT
//   illegal             - one-cycle pulse when an undefined opcode executes
//   retired             - count of executed instructions (wraps)
module fetch_decode (
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   input  logic [31:0] PC,
   input  logic [31:0] instr_data,
   input  logic        instr_valid,
   output logic        instr_req,
   output logic [9:0]  instr_addr,
   output logic [4:0]  alucode,
   output logic [2:0]  op1,
   output logic [20:0] op2,
   output logic        imControl,
   output logic        flag,
   output logic        flag1,
   output logic        writecode,
   output logic        regenable,
   output logic [1:0]  ramenable,
   output logic [3:0]  pcControl,
   output logic        halted,
   output logic        illegal,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      DECODE  = 3'd2,
      EXECUTE = 3'd3,
      HALT    = 3'd4
   } state_t;

   localparam logic [3:0] PC_HOLD = 4'd10;
   localparam logic [4:0] OP_MOV  = 5'd12;
   localparam logic [4:0] OP_HALT = 5'd22;

   state_t      state;
   state_t      state_next;
   logic [31:0] ir;

   // Controls decoded from IR in DECODE and held for the EXECUTE cycle.
   logic [4:0]  d_alucode;
   logic        d_writecode;
   logic        d_regenable;
   logic [1:0]  d_ramenable;
   logic [3:0]  d_pcControl;
   logic        d_illegal;
   logic        d_halt;

   logic [4:0]  dec_alucode;
   logic        dec_writecode;
   logic        dec_regenable;
   logic [1:0]  dec_ramenable;
   logic [3:0]  dec_pcControl;
   logic        dec_illegal;
   logic        dec_halt;

   logic [4:0]  opcode;
   logic [4:0]  branch_code;

   // Only the low ten PC bits address instruction memory.
   logic        unused_pc;
   assign unused_pc = ^PC[31:10];

   assign opcode      = ir[31:27];
   assign branch_code = opcode - OP_MOV;

   // Instruction decode from IR
   always_comb begin
      dec_alucode   = 5'd0;
      dec_writecode = 1'b0;
      dec_regenable = 1'b0;
      dec_pcControl = 4'd0;
      dec_illegal   = 1'b0;
      dec_halt      = 1'b0;
      if (opcode < OP_MOV) begin
         dec_alucode   = opcode;
         dec_regenable = 1'b1;
      end else if (opcode == OP_MOV) begin
         dec_writecode = 1'b1;
         dec_regenable = 1'b1;
      end else if (opcode < OP_HALT) begin
         dec_pcControl = branch_code[3:0];
      end else if (opcode == OP_HALT) begin
         dec_halt = 1'b1;
      end else begin
         dec_illegal = 1'b1;
      end
      // RAM read follows the indirect flags for every instruction class;
      // RAM write only for ALU/MOV with an indirect destination, which
      // then replaces the register write.
      dec_ramenable[0] = ir[23] | ir[22];
      dec_ramenable[1] = ir[23] & (opcode <= OP_MOV);
      if (dec_ramenable[1]) begin
         dec_regenable = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         ir          <= 32'd0;
         retired     <= 32'd0;
         d_alucode   <= 5'd0;
         d_writecode <= 1'b0;
         d_regenable <= 1'b0;
         d_ramenable <= 2'b00;
         d_pcControl <= 4'd0;
         d_illegal   <= 1'b0;
         d_halt      <= 1'b0;
      end else begin
         state <= state_next;
         if (state == FETCH && instr_valid) begin
            ir <= instr_data;
         end
         if (state == DECODE) begin
            d_alucode   <= dec_alucode;
            d_writecode <= dec_writecode;
            d_regenable <= dec_regenable;
            d_ramenable <= dec_ramenable;
            d_pcControl <= dec_pcControl;
            d_illegal   <= dec_illegal;
            d_halt      <= dec_halt;
         end
         if (state == EXECUTE) begin
            retired <= retired + 32'd1;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (run) state_next = FETCH;
         FETCH:   if (instr_valid) state_next = DECODE;
         DECODE:  state_next = EXECUTE;
         EXECUTE: state_next = d_halt ? HALT : FETCH;
         HALT:    state_next = HALT;
         default: state_next = IDLE;
      endcase
   end

   // Outputs: datapath strobes are only live in EXECUTE
   always_comb begin
      instr_req = (state == FETCH);
      halted    = (state == HALT);
      alucode   = 5'd0;
      writecode = 1'b0;
      regenable = 1'b0;
      ramenable = 2'b00;
      pcControl = PC_HOLD;
      illegal   = 1'b0;
      if (state == EXECUTE) begin
         alucode   = d_alucode;
         writecode = d_writecode;
         regenable = d_regenable;
         ramenable = d_ramenable;
         pcControl = d_pcControl;
         illegal   = d_illegal;
      end
   end

   assign instr_addr = PC[9:0];
   assign op1        = ir[26:24];
   assign flag       = ir[23];
   assign flag1      = ir[22];
   assign imControl  = ir[21];
   assign op2        = ir[20:0];

endmodule

// File: tb/tb_fetch_decode.sv
`timescale 1ns/1ps
module tb_fetch_decode;

   logic        clock = 1'b0;
   logic        reset;
   logic        run;
   logic [31:0] PC;
   logic [31:0] instr_data;
   logic        instr_valid;
   logic        instr_req;
   logic [9:0]  instr_addr;
   logic [4:0]  alucode;
   logic [2:0]  op1;
   logic [20:0] op2;
   logic        imControl;
   logic        flag;
   logic        flag1;
   logic        writecode;
   logic        regenable;
   logic [1:0]  ramenable;
   logic [3:0]  pcControl;
   logic        halted;
   logic        illegal;
   logic [31:0] retired;

   int passed = 0;
   int total  = 0;
   logic [31:0] exp_ret;

   fetch_decode dut (
      .clock(clock), .reset(reset), .run(run), .PC(PC),
      .instr_data(instr_data), .instr_valid(instr_valid),
      .instr_req(instr_req), .instr_addr(instr_addr), .alucode(alucode),
      .op1(op1), .op2(op2), .imControl(imControl), .flag(flag), .flag1(flag1),
      .writecode(writecode), .regenable(regenable), .ramenable(ramenable),
      .pcControl(pcControl), .halted(halted), .illegal(illegal), .retired(retired)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Called while in FETCH; returns positioned in the EXECUTE cycle.
   task automatic exec_instr(input logic [31:0] ins);
      instr_data  = ins;
      instr_valid = 1'b1;
      step();               // now DECODE
      instr_valid = 1'b0;
      step();               // now EXECUTE
   endtask

   task automatic test_reset();
      reset = 1'b1; run = 1'b0; instr_valid = 1'b0; instr_data = 32'd0; PC = 32'h0000_0123;
      step(); step();
      total++; if (instr_req !== 1'b0) $display("FAIL reset_req got %b want 0", instr_req); else passed++;
      total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else passed++;
      total++; if (pcControl !== 4'd10) $display("FAIL reset_pc got %0d want 10", pcControl); else passed++;
      total++; if ({regenable, ramenable, illegal} !== 4'b0) $display("FAIL reset_strobes got %b want 0000", {regenable, ramenable, illegal}); else passed++;
      total++; if (retired !== 32'd0) $display("FAIL reset_retired got %0d want 0", retired); else passed++;
      total++; if (op2 !== 21'd0) $display("FAIL reset_ir got %h want 0", op2); else passed++;
      reset = 1'b0;
      exp_ret = 32'd0;
   endtask

   task automatic test_add();
      // Immediate return in the first FETCH cycle; literal vector carries flag=1.
      run = 1'b1;
      step();               // FETCH
      run = 1'b0;
      total++; if (instr_req !== 1'b1) $display("FAIL add_req got %b want 1", instr_req); else passed++;
      total++; if (instr_addr !== 10'h123) $display("FAIL add_addr got %h want 123", instr_addr); else passed++;
      instr_data = 32'h08A0_0005; instr_valid = 1'b1;
      step();               // DECODE
      instr_valid = 1'b0;
      total++; if (instr_req !== 1'b0 || pcControl !== 4'd10 || regenable !== 1'b0) $display("FAIL add_decode got req=%b pc=%0d re=%b want 0/10/0", instr_req, pcControl, regenable); else passed++;
      total++; if ({op1, flag, flag1, imControl, op2} !== {3'd0, 1'b1, 1'b0, 1'b1, 21'd5}) $display("FAIL add_fields got op1=%0d f=%b f1=%b im=%b op2=%0d want 0 1 0 1 5", op1, flag, flag1, imControl, op2); else passed++;
      step();               // EXECUTE
      total++; if (alucode !== 5'd1 || pcControl !== 4'd0) $display("FAIL add_exec got alu=%0d pc=%0d want 1/0", alucode, pcControl); else passed++;
      total++; if (ramenable !== 2'b11 || regenable !== 1'b0 || writecode !== 1'b0) $display("FAIL add_ram got ram=%b re=%b wc=%b want 11/0/0", ramenable, regenable, writecode); else passed++;
      total++; if (retired !== exp_ret) $display("FAIL add_ret_pre got %0d want %0d", retired, exp_ret); else passed++;
      step();               // FETCH again, 3 cycles after the first
      exp_ret = exp_ret + 1;
      total++; if (instr_req !== 1'b1 || retired !== exp_ret) $display("FAIL add_refetch got req=%b ret=%0d want 1/%0d", instr_req, retired, exp_ret); else passed++;
      // ADD r5, #5 without indirection: plain register write
      exec_instr(32'h0D20_0005);
      total++; if (alucode !== 5'd1 || regenable !== 1'b1 || ramenable !== 2'b00 || op1 !== 3'd5 || imControl !== 1'b1 || op2 !== 21'd5) $display("FAIL add2_exec got alu=%0d re=%b ram=%b op1=%0d im=%b op2=%0d want 1 1 00 5 1 5", alucode, regenable, ramenable, op1, imControl, op2); else passed++;
      step();
      exp_ret = exp_ret + 1;
      total++; if (alucode !== 5'd0 || regenable !== 1'b0 || pcControl !== 4'd10) $display("FAIL add2_after got alu=%0d re=%b pc=%0d want 0/0/10", alucode, regenable, pcControl); else passed++;
   endtask

   task automatic test_delayed_valid();
      int held;
      held = 0;
      instr_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (instr_req === 1'b1 && pcControl === 4'd10) held++;
      end
      total++; if (held !== 4) $display("FAIL delay_hold got %0d want 4 held cycles", held); else passed++;
      exec_instr(32'h5B00_0007);   // opcode 11, op1=3, op2=7
      total++; if (alucode !== 5'd11 || regenable !== 1'b1 || op1 !== 3'd3 || op2 !== 21'd7) $display("FAIL delay_exec got alu=%0d re=%b op1=%0d op2=%0d want 11 1 3 7", alucode, regenable, op1, op2); else passed++;
      step();
      exp_ret = exp_ret + 1;
      total++; if (retired !== exp_ret) $display("FAIL delay_ret got %0d want %0d", retired, exp_ret); else passed++;
   endtask

   task automatic test_branch();
      exec_instr(32'hA800_0040);   // opcode 21
      total++; if (pcControl !== 4'd9 || regenable !== 1'b0 || op2 !== 21'h40) $display("FAIL jump21 got pc=%0d re=%b op2=%h want 9/0/40", pcControl, regenable, op2); else passed++;
      step(); exp_ret = exp_ret + 1;
      exec_instr(32'h6800_0000);   // opcode 13
      total++; if (pcControl !== 4'd1 || regenable !== 1'b0) $display("FAIL br13 got pc=%0d re=%b want 1/0", pcControl, regenable); else passed++;
      step(); exp_ret = exp_ret + 1;
   endtask

   task automatic test_indirect();
      exec_instr(32'h0080_0000);   // opcode 0, flag=1
      total++; if (ramenable !== 2'b11 || regenable !== 1'b0 || alucode !== 5'd0) $display("FAIL ind_alu got ram=%b re=%b alu=%0d want 11/0/0", ramenable, regenable, alucode); else passed++;
      step(); exp_ret = exp_ret + 1;
      exec_instr(32'h6040_0000);   // opcode 12 (MOV), flag1=1
      total++; if (ramenable !== 2'b01 || writecode !== 1'b1 || regenable !== 1'b1 || pcControl !== 4'd0) $display("FAIL ind_mov got ram=%b wc=%b re=%b pc=%0d want 01/1/1/0", ramenable, writecode, regenable, pcControl); else passed++;
      step(); exp_ret = exp_ret + 1;
      total++; if (retired !== exp_ret) $display("FAIL ind_ret got %0d want %0d", retired, exp_ret); else passed++;
   endtask

   task automatic test_illegal_and_reset_fetch();
      exec_instr(32'hF800_0000);   // opcode 31
      total++; if (illegal !== 1'b1 || regenable !== 1'b0 || ramenable !== 2'b00 || pcControl !== 4'd0) $display("FAIL nop31 got ill=%b re=%b ram=%b pc=%0d want 1/0/00/0", illegal, regenable, ramenable, pcControl); else passed++;
      step(); exp_ret = exp_ret + 1;
      total++; if (illegal !== 1'b0 || instr_req !== 1'b1 || retired !== exp_ret) $display("FAIL nop31_after got ill=%b req=%b ret=%0d want 0/1/%0d", illegal, instr_req, retired, exp_ret); else passed++;
      // Reset with a simultaneous fetch response: response must be dropped.
      reset = 1'b1; instr_valid = 1'b1; instr_data = 32'h1234_5678;
      step();
      reset = 1'b0; instr_valid = 1'b0;
      total++; if (op2 !== 21'd0 || op1 !== 3'd0 || instr_req !== 1'b0 || retired !== 32'd0) $display("FAIL rst_fetch got op2=%h op1=%0d req=%b ret=%0d want 0 0 0 0", op2, op1, instr_req, retired); else passed++;
      step();
      total++; if (instr_req !== 1'b0 || pcControl !== 4'd10) $display("FAIL rst_idle got req=%b pc=%0d want 0/10", instr_req, pcControl); else passed++;
      exp_ret = 32'd0;
   endtask

   task automatic test_halt();
      int ok;
      run = 1'b1; step(); run = 1'b0;   // FETCH
      exec_instr(32'h0D20_0005);
      step(); exp_ret = exp_ret + 1;
      exec_instr(32'hB000_0011);        // opcode 22
      total++; if (pcControl !== 4'd0 || halted !== 1'b0 || retired !== exp_ret) $display("FAIL halt_exec got pc=%0d h=%b ret=%0d want 0/0/%0d", pcControl, halted, retired, exp_ret); else passed++;
      step(); exp_ret = exp_ret + 1;
      total++; if (halted !== 1'b1 || retired !== exp_ret) $display("FAIL halt_enter got h=%b ret=%0d want 1/%0d", halted, retired, exp_ret); else passed++;
      ok = 0;
      instr_valid = 1'b1; instr_data = 32'h0D20_0001; run = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (halted === 1'b1 && instr_req === 1'b0 && retired === exp_ret && op2 === 21'h11 && pcControl === 4'd10) ok++;
      end
      instr_valid = 1'b0; run = 1'b0;
      total++; if (ok !== 6) $display("FAIL halt_hold got %0d want 6 frozen cycles", ok); else passed++;
      reset = 1'b1; step(); reset = 1'b0;
      total++; if (halted !== 1'b0 || retired !== 32'd0 || instr_req !== 1'b0 || op2 !== 21'd0) $display("FAIL halt_reset got h=%b ret=%0d req=%b op2=%h want 0 0 0 0", halted, retired, instr_req, op2); else passed++;
   endtask

   initial begin
      test_reset();
      test_add();
      test_delayed_valid();
      test_branch();
      test_indirect();
      test_illegal_and_reset_fetch();
      test_halt();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
